pipe_stage_skid: RTL and testbench

//  Parametrised elastic pipeline-stage register, generalising the fixed ID/EX-style latch.

---
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: head + skid entry behind a valid/ready handshake,
// with flush, debug-unit freeze and a saturating bubble counter.
module pipe_stage_skid #(
  parameter int                 NB_DATA     = 128,
  parameter int                 NB_CTRL     = 18,
  parameter logic [NB_CTRL-1:0] BUBBLE_CTRL = '0,
  parameter int                 NB_CNT      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_CTRL-1:0] i_ctrl,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [1:0]         o_occupancy,
  output logic [NB_CNT-1:0]  o_bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [NB_DATA-1:0] head_data_reg, head_data_next;
  logic [NB_CTRL-1:0] head_ctrl_reg, head_ctrl_next;
  logic [NB_DATA-1:0] skid_data_reg, skid_data_next;
  logic [NB_CTRL-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [NB_CNT-1:0]  bubble_cnt_reg, bubble_cnt_next;
  logic               acc_fire;
  logic               out_fire;

  // Handshake outputs depend only on registered state, never on i_ready.
  assign o_ready     = i_dunit_clk_en & (state_reg != ST_TWO);
  assign o_valid     = i_dunit_clk_en & (state_reg != ST_EMPTY);
  assign acc_fire    = i_valid & o_ready;
  assign out_fire    = o_valid & i_ready;
  assign o_data      = head_data_reg;
  assign o_ctrl      = (state_reg != ST_EMPTY) ? head_ctrl_reg : BUBBLE_CTRL;
  assign o_occupancy = state_reg;
  assign o_bubble_cnt = bubble_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= ST_EMPTY;
      head_data_reg  <= '0;
      head_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
      skid_ctrl_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      head_data_reg  <= head_data_next;
      head_ctrl_reg  <= head_ctrl_next;
      skid_data_reg  <= skid_data_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    head_data_next  = head_data_reg;
    head_ctrl_next  = head_ctrl_reg;
    skid_data_next  = skid_data_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    bubble_cnt_next = bubble_cnt_reg;

    if (i_dunit_clk_en) begin
      // Flush drops everything held plus this cycle's input; a concurrent output
      // transfer still counts as delivered on the downstream side.
      if (i_flush) begin
        state_next     = ST_EMPTY;
        head_data_next = '0;
        head_ctrl_next = '0;
        skid_data_next = '0;
        skid_ctrl_next = '0;
      end else begin
        case (state_reg)
          ST_EMPTY: begin
            if (acc_fire) begin
              state_next     = ST_ONE;
              head_data_next = i_data;
              head_ctrl_next = i_ctrl;
            end
          end
          ST_ONE: begin
            if (acc_fire && out_fire) begin
              head_data_next = i_data;
              head_ctrl_next = i_ctrl;
            end else if (acc_fire) begin
              state_next     = ST_TWO;
              skid_data_next = i_data;
              skid_ctrl_next = i_ctrl;
            end else if (out_fire) begin
              state_next = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_next     = ST_ONE;
              head_data_next = skid_data_reg;
              head_ctrl_next = skid_ctrl_reg;
            end
          end
          default: state_next = ST_EMPTY;
        endcase
      end

      if (i_ready && !o_valid && (bubble_cnt_reg != {NB_CNT{1'b1}})) begin
        bubble_cnt_next = bubble_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (small build, NB_CNT=4).
module tb_pipe_stage_skid;

  localparam int              NB_DATA = 16;
  localparam int              NB_CTRL = 8;
  localparam int              NB_CNT  = 4;
  localparam logic [7:0]      BUBBLE  = 8'hA5;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_dunit_clk_en;
  logic         i_flush;
  logic         i_valid;
  logic         o_ready;
  logic [15:0]  i_data;
  logic [7:0]   i_ctrl;
  logic         o_valid;
  logic         i_ready;
  logic [15:0]  o_data;
  logic [7:0]   o_ctrl;
  logic [1:0]   o_occupancy;
  logic [3:0]   o_bubble_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] s1 [5] = '{16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05};

  always #5 i_clk = ~i_clk;

  pipe_stage_skid #(
    .NB_DATA     (NB_DATA),
    .NB_CTRL     (NB_CTRL),
    .BUBBLE_CTRL (BUBBLE),
    .NB_CNT      (NB_CNT)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_dunit_clk_en (i_dunit_clk_en),
    .i_flush        (i_flush),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_ctrl         (i_ctrl),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_ctrl         (o_ctrl),
    .o_occupancy    (o_occupancy),
    .o_bubble_cnt   (o_bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [7:0] ctrl_of(input logic [15:0] d);
    return d[7:0] ^ 8'h3C;
  endfunction

  task automatic drive(input logic en, input logic flush, input logic valid,
                       input logic [15:0] data, input logic ready);
    i_dunit_clk_en = en;
    i_flush        = flush;
    i_valid        = valid;
    i_data         = data;
    i_ctrl         = ctrl_of(data);
    i_ready        = ready;
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    next_cycle();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    next_cycle();
    next_cycle();
    #1;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_occ", o_occupancy, 0);
    check_eq("rst_ctrl", o_ctrl, BUBBLE);
    check_eq("rst_cnt", o_bubble_cnt, 0);
    i_reset = 1'b0;
    next_cycle();

    // Streaming A..E with i_ready=1: one per cycle, latency 1
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, s1[i], 1'b1);
      #1;
      check_eq("t1_ready", o_ready, 1);
      if (i == 0) begin
        check_eq("t1_valid_first", o_valid, 0);
      end else begin
        check_eq("t1_valid", o_valid, 1);
        check_eq("t1_data", o_data, s1[i-1]);
        check_eq("t1_ctrl", o_ctrl, ctrl_of(s1[i-1]));
        check_eq("t1_occ", o_occupancy, 1);
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    check_eq("t1_last_data", o_data, s1[4]);
    check_eq("t1_last_valid", o_valid, 1);
    check_eq("t1_cnt", o_bubble_cnt, 1);
    next_cycle();
    #1;
    check_eq("t1_drained_valid", o_valid, 0);
    check_eq("t1_drained_ctrl", o_ctrl, BUBBLE);
    check_eq("t1_drained_occ", o_occupancy, 0);
    next_cycle();

    // Fill with downstream stalled, then drain in order
    drive(1'b1, 1'b0, 1'b1, 16'h2A11, 1'b0);
    #1;
    check_eq("t2_ready_a", o_ready, 1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h2B12, 1'b0);
    #1;
    check_eq("t2_occ_one", o_occupancy, 1);
    check_eq("t2_ready_b", o_ready, 1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h2C13, 1'b0);
    #1;
    check_eq("t2_occ_two", o_occupancy, 2);
    check_eq("t2_ready_full", o_ready, 0);
    check_eq("t2_head_a", o_data, 16'h2A11);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h2C13, 1'b1);
    #1;
    check_eq("t2_ready_still_full", o_ready, 0);
    check_eq("t2_out_a", o_data, 16'h2A11);
    check_eq("t2_out_a_valid", o_valid, 1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h2C13, 1'b1);
    #1;
    check_eq("t2_out_b", o_data, 16'h2B12);
    check_eq("t2_out_b_ctrl", o_ctrl, ctrl_of(16'h2B12));
    check_eq("t2_occ_back_one", o_occupancy, 1);
    check_eq("t2_ready_again", o_ready, 1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    check_eq("t2_out_c", o_data, 16'h2C13);
    check_eq("t2_out_c_valid", o_valid, 1);
    next_cycle();
    #1;
    check_eq("t2_empty", o_valid, 0);
    next_cycle();

    // Flush while full with a valid input X
    drive(1'b1, 1'b0, 1'b1, 16'h3F21, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h3F22, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 16'h7777, 1'b0);
    #1;
    check_eq("t3_pre_occ", o_occupancy, 2);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    check_eq("t3_occ", o_occupancy, 0);
    check_eq("t3_valid", o_valid, 0);
    check_eq("t3_ctrl", o_ctrl, BUBBLE);
    check_eq("t3_data_zero", o_data, 16'h0);
    next_cycle();
    #1;
    check_eq("t3_x_absent", o_valid, 0);
    next_cycle();

    // Freeze in ONE: nothing moves, bubble counter holds
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h4A31, 1'b0);
    #1;
    check_eq("t4_cnt_pre", o_bubble_cnt, 2);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h4B32, 1'b1);
      #1;
      check_eq("t4_frz_valid", o_valid, 0);
      check_eq("t4_frz_ready", o_ready, 0);
      check_eq("t4_frz_head", o_data, 16'h4A31);
      check_eq("t4_frz_occ", o_occupancy, 1);
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    #1;
    check_eq("t4_frz_cnt", o_bubble_cnt, 2);
    check_eq("t4_deliver_valid", o_valid, 1);
    check_eq("t4_deliver_data", o_data, 16'h4A31);
    next_cycle();
    #1;
    check_eq("t4_once", o_valid, 0);
    check_eq("t4_cnt_post", o_bubble_cnt, 2);
    next_cycle();

    // Bubble counter saturation
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) next_cycle();
    #1;
    check_eq("t5_cnt_10", o_bubble_cnt, 10);
    for (int i = 0; i < 11; i++) next_cycle();
    #1;
    check_eq("t5_cnt_sat", o_bubble_cnt, 15);
    next_cycle();
    next_cycle();
    #1;
    check_eq("t5_cnt_hold", o_bubble_cnt, 15);

    // Reset overrides flush and freeze while full
    drive(1'b1, 1'b0, 1'b1, 16'h6A41, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 16'h6B42, 1'b0);
    next_cycle();
    #1;
    check_eq("t6_pre_occ", o_occupancy, 2);
    i_reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h6C43, 1'b1);
    next_cycle();
    i_reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    #1;
    check_eq("t6_valid", o_valid, 0);
    check_eq("t6_ready", o_ready, 1);
    check_eq("t6_occ", o_occupancy, 0);
    check_eq("t6_ctrl", o_ctrl, BUBBLE);
    check_eq("t6_data", o_data, 16'h0);
    check_eq("t6_cnt", o_bubble_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
